// File: rtl/camera_frame_reader_pkg.sv
// Shared types and defaults for the camera frame reader.
package camera_frame_reader_pkg;

  localparam int unsigned DEFAULT_FRAME_WORDS = 76800;
  localparam int unsigned DEFAULT_ADDR_W      = 17;
  localparam int unsigned DEFAULT_FIFO_DEPTH  = 4;

  // Reader control states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_REL    = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  // One FIFO entry: frame markers plus the RGB565 pixel (18 bits total).
  typedef struct packed {
    logic        eof;
    logic        sof;
    logic [15:0] data;
  } pix_word_t;

endpackage

// File: rtl/camera_frame_reader_if.sv
// Bus bundle between the frame reader and its environment:
// capture-block handshake, RAM read port and the outgoing pixel stream.
interface camera_frame_reader_if
  import camera_frame_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);

  logic              cam_valid;
  logic              cam_ready;
  logic [ADDR_W-1:0] ram_raddr;
  logic [31:0]       ram_rdata;
  logic [15:0]       pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eof;

  modport master (
    output cam_valid, ram_raddr, pix_data, pix_valid, pix_sof, pix_eof,
    input  cam_ready, ram_rdata, pix_ready
  );

  modport slave (
    input  cam_valid, ram_raddr, pix_data, pix_valid, pix_sof, pix_eof,
    output cam_ready, ram_rdata, pix_ready
  );

endinterface

// File: rtl/camera_frame_reader_pixel_fifo.sv
// Synchronous show-ahead FIFO for pixel words; flush has priority over push/pop.
module camera_frame_reader_pixel_fifo
  import camera_frame_reader_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  pix_word_t        din,
  output pix_word_t        dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  pix_word_t        mem_q [DEPTH];
  pix_word_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Next-state: pointer/count update, storage write.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push & (count_q != DEPTH_C);
    do_pop   = pop & (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Status and head-of-queue output; head reads as zero when empty.
  always_comb begin
    count = count_q;
    empty = (count_q == '0);
    full  = (count_q == DEPTH_C);
    dout  = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/camera_frame_reader.sv
// Frame reader: arms the capture block, waits for a stored frame, releases
// the capture block, then streams the frame from RAM as a valid/ready pixel stream.
module camera_frame_reader
  import camera_frame_reader_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = DEFAULT_FRAME_WORDS,
  parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  camera_frame_reader_if.master bus
);

  localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W:0]    DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              inflight_q, inflight_d;
  logic              infl_sof_q, infl_sof_d;
  logic              infl_eof_q, infl_eof_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cam_valid_q, cam_valid_d;

  logic              fifo_flush;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic              room;
  pix_word_t         fifo_din;
  pix_word_t         fifo_dout;
  logic              unused_ok;

  // Next-state, read issue and done generation; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    inflight_d = 1'b0;
    infl_sof_d = infl_sof_q;
    infl_eof_d = infl_eof_q;
    done_d     = 1'b0;
    fifo_flush = 1'b0;
    // A read may issue only if its data plus any in-flight word still fits.
    occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    room       = (occupancy < DEPTH_OCC);

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (bus.cam_ready) state_d = ST_REL;
      end
      ST_REL: begin
        if (!bus.cam_ready) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (room) begin
          inflight_d = 1'b1;
          infl_sof_d = (rd_addr_q == '0);
          infl_eof_d = (rd_addr_q == LAST_ADDR);
          // Address parks on the last word so it never wraps past the frame.
          if (rd_addr_q == LAST_ADDR) state_d = ST_DRAIN;
          else                        rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !inflight_q) begin
          done_d    = 1'b1;
          state_d   = ST_IDLE;
          rd_addr_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      rd_addr_d  = '0;
      inflight_d = 1'b0;
      done_d     = 1'b0;
      fifo_flush = 1'b1;
    end

    busy_d      = (state_d != ST_IDLE);
    cam_valid_d = (state_d == ST_ARM);
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      inflight_q  <= 1'b0;
      infl_sof_q  <= 1'b0;
      infl_eof_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cam_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      inflight_q  <= inflight_d;
      infl_sof_q  <= infl_sof_d;
      infl_eof_q  <= infl_eof_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cam_valid_q <= cam_valid_d;
    end
  end

  // FIFO write data arrives one cycle after issue; head drives the stream.
  always_comb begin
    fifo_din.eof  = infl_eof_q;
    fifo_din.sof  = infl_sof_q;
    fifo_din.data = bus.ram_rdata[15:0];
    fifo_pop      = ~fifo_empty & bus.pix_ready;
    busy          = busy_q;
    done          = done_q;
    bus.cam_valid = cam_valid_q;
    bus.ram_raddr = rd_addr_q;
    bus.pix_valid = ~fifo_empty;
    bus.pix_data  = fifo_dout.data;
    bus.pix_sof   = fifo_dout.sof;
    bus.pix_eof   = fifo_dout.eof;
    unused_ok     = ^{bus.ram_rdata[31:16], fifo_full};
  end

  camera_frame_reader_pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (inflight_q),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_camera_frame_reader.sv
// Directed/randomized bench for camera_frame_reader with an 8-word frame.
module tb_camera_frame_reader;

  localparam int unsigned FW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned FD = 4;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic start;
  logic abort;
  logic busy;
  logic done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc_g       = 0;
  int cam_hi      = 0;
  int cam_lo      = 0;
  int cam_fall    = -1000;
  bit hold_ready  = 1'b0;

  camera_frame_reader_if #(.ADDR_W(AW)) bus ();

  camera_frame_reader #(
    .FRAME_WORDS (FW),
    .ADDR_W      (AW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  // RAM: word i holds 0x1000+i in the low half, junk in the high half; 1-cycle read latency.
  always @(posedge HCLK) bus.ram_rdata <= {16'($urandom()), 16'h1000 + 16'(bus.ram_raddr)};

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; then the capture-block model reacts to cam_valid.
  task automatic tick();
    @(posedge HCLK);
    #1;
    cyc_g++;
    if (hold_ready) begin
      bus.cam_ready = 1'b1;
      cam_lo = 0;
    end else if (bus.cam_valid) begin
      cam_lo = 0;
      cam_hi++;
      if (cam_hi >= 20) bus.cam_ready = 1'b1;
    end else begin
      cam_hi = 0;
      if (bus.cam_ready) begin
        cam_lo++;
        if (cam_lo >= 2) begin
          bus.cam_ready = 1'b0;
          cam_lo = 0;
          cam_fall = cyc_g;
        end
      end
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_busy"},      busy,          0);
    chk({pfx, "_done"},      done,          0);
    chk({pfx, "_cam_valid"}, bus.cam_valid, 0);
    chk({pfx, "_raddr"},     bus.ram_raddr, 0);
    chk({pfx, "_pix_valid"}, bus.pix_valid, 0);
    chk({pfx, "_pix_sof"},   bus.pix_sof,   0);
    chk({pfx, "_pix_eof"},   bus.pix_eof,   0);
    chk({pfx, "_pix_data"},  bus.pix_data,  0);
  endtask

  // Start one frame and follow it against the expected pixel sequence.
  task automatic run_frame(input int pct, input int abort_at, input int rst_at,
                           input int restart_at, input int cam_hi_exp, input bit check_rate);
    int k = 0;
    int n = 0;
    int done_exp = -1;
    int first_v = -1;
    int first_hs = -1;
    int last_hs = -1;
    int cam_cnt = 0;
    bit ended = 1'b0;
    bit hs, stall, did_abort, did_rst;
    logic [15:0] pd;
    logic ps, pe;
    start = 1'b1;
    while (!ended && n < 400) begin
      bus.pix_ready = ($urandom_range(99, 0) < pct);
      #0;
      hs    = bus.pix_valid & bus.pix_ready;
      stall = bus.pix_valid & ~bus.pix_ready;
      pd = bus.pix_data;
      ps = bus.pix_sof;
      pe = bus.pix_eof;
      did_abort = 1'b0;
      did_rst   = 1'b0;
      if (hs) begin
        chk("pix_in_frame", 32'(k < FW), 1);
        chk("pix_data", bus.pix_data, 32'h1000 + k);
        chk("pix_sof",  bus.pix_sof,  32'(k == 0));
        chk("pix_eof",  bus.pix_eof,  32'(k == FW - 1));
        if (abort_at == k)   begin abort = 1'b1;   did_abort = 1'b1; end
        if (rst_at == k)     begin HRESETn = 1'b0; did_rst = 1'b1;   end
        if (restart_at == k) start = 1'b1;
      end
      tick();
      n++;
      start = 1'b0;
      abort = 1'b0;
      if (did_abort) begin
        chk("abort_pix_valid", bus.pix_valid, 0);
        chk("abort_busy",      busy,          0);
        chk("abort_done",      done,          0);
        chk("abort_cam_valid", bus.cam_valid, 0);
        repeat (20) begin
          tick();
          chk("post_abort_done", done, 0);
          chk("post_abort_busy", busy, 0);
          chk("post_abort_pix_valid", bus.pix_valid, 0);
        end
        return;
      end
      if (did_rst) begin
        HRESETn = 1'b1;
        check_reset("midrst");
        repeat (10) begin
          tick();
          chk("post_rst_raddr", bus.ram_raddr, 0);
          chk("post_rst_busy",  busy,          0);
        end
        return;
      end
      if (hs) begin
        if (first_hs < 0) first_hs = cyc_g;
        last_hs = cyc_g;
        k++;
        if (k == FW) done_exp = cyc_g + 1;
      end
      if (stall) begin
        chk("stall_valid", bus.pix_valid, 1);
        chk("stall_data",  bus.pix_data,  pd);
        chk("stall_sof",   bus.pix_sof,   ps);
        chk("stall_eof",   bus.pix_eof,   pe);
      end
      chk("done", done, 32'(cyc_g == done_exp));
      chk("busy", busy, 32'(cyc_g != done_exp));
      if (bus.cam_valid) cam_cnt++;
      if (bus.pix_valid && first_v < 0) first_v = cyc_g;
      if (done) ended = 1'b1;
    end
    chk("frame_completed", 32'(ended), 1);
    chk("pixel_count", k, FW);
    chk("cam_valid_cycles", cam_cnt, cam_hi_exp);
    chk("first_valid_latency", first_v - cam_fall, 3);
    if (check_rate) chk("throughput", last_hs - first_hs, FW - 1);
    bus.pix_ready = 1'b1;
    repeat (5) begin
      tick();
      chk("idle_done",      done,          0);
      chk("idle_busy",      busy,          0);
      chk("idle_pix_valid", bus.pix_valid, 0);
      chk("idle_cam_valid", bus.cam_valid, 0);
    end
  endtask

  initial begin
    HRESETn       = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    bus.pix_ready = 1'b0;
    bus.cam_ready = 1'b0;
    repeat (3) tick();
    check_reset("reset");
    HRESETn = 1'b1;
    tick();
    check_reset("idle");

    // Full-rate frame.
    run_frame(100, -1, -1, -1, 20, 1'b1);
    // Random back-pressure.
    run_frame(50, -1, -1, -1, 20, 1'b0);
    run_frame(50, -1, -1, -1, 20, 1'b0);
    // Abort on acceptance of pixel 3, then a clean frame.
    run_frame(60, 3, -1, -1, 20, 1'b0);
    run_frame(100, -1, -1, -1, 20, 1'b1);
    // Start while streaming is ignored.
    run_frame(70, -1, -1, 2, 20, 1'b0);
    // Start together with abort from idle: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_cam_valid", bus.cam_valid, 0);
    repeat (10) begin
      tick();
      chk("start_abort_idle_busy", busy, 0);
      chk("start_abort_idle_pix_valid", bus.pix_valid, 0);
    end
    // Stale cam_ready held in idle.
    hold_ready = 1'b1;
    repeat (10) begin
      tick();
      chk("stale_ready_busy", busy, 0);
      chk("stale_ready_cam_valid", bus.cam_valid, 0);
      chk("stale_ready_pix_valid", bus.pix_valid, 0);
    end
    hold_ready = 1'b0;
    run_frame(100, -1, -1, -1, 1, 1'b1);
    // One-cycle reset mid-stream, then a clean frame.
    run_frame(100, -1, 2, -1, 20, 1'b0);
    run_frame(100, -1, -1, -1, 20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
